// File: rtl/int_controller.sv
// Prioritised interrupt controller: rising-edge request latching, mask/pending register window,
// and vector drive during the CPU intack cycle. Define INTC_NESTING_EN to add the in-service register.
module int_controller #(
    parameter int          NUM_SRC    = 8,
    parameter logic [11:0] BASE_ADDR  = 12'hFF0,
    parameter int          VEC_OFFSET = 0,
    parameter int          SPUR_VEC   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_req,
    input  logic [11:0]        address,
    input  logic [15:0]        data_out,
    input  logic               memwt,
    input  logic               intack,
    output logic               int_req,
    output logic [15:0]        rd_data,
    output logic               rd_sel
);

    localparam logic [3:0] VEC_OFF4 = 4'(VEC_OFFSET);
    localparam logic [3:0] SPUR4    = 4'(SPUR_VEC);

    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pend_d;
    logic [NUM_SRC-1:0] req_d;
    logic               armed_q;
    logic [NUM_SRC-1:0] set_edge;
    logic [NUM_SRC-1:0] gate;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] win_oh;
    logic [NUM_SRC-1:0] clr_ack;
    logic [NUM_SRC-1:0] clr_w1c;
    logic               any_elig;
    logic [3:0]         win_idx;
    logic [3:0]         vec;
    logic [12:0]        addr_diff;
    logic               hit;
    logic [1:0]         offset;
    logic               rd_hit;
    logic               wr_mask;
    logic               wr_pend;
    logic [15:0]        reg_rd;
    logic [NUM_SRC-1:0] wdata;
    logic               unused_wdata;

    assign wdata        = data_out[NUM_SRC-1:0];
    assign unused_wdata = ^data_out[15:NUM_SRC];

    // 13-bit difference so addresses below the base never alias into the window
    always_comb begin
        addr_diff = {1'b0, address} - {1'b0, BASE_ADDR};
        hit       = ~addr_diff[12] & (addr_diff[11:2] == 10'd0);
        offset    = addr_diff[1:0];
        rd_hit    = hit & ~memwt;
        wr_mask   = hit & memwt & (offset == 2'd0);
        wr_pend   = hit & memwt & (offset == 2'd1);
    end

    // A line already high when reset releases is not an edge; armed_q masks the first sample.
    assign set_edge = src_req & ~req_d & {NUM_SRC{armed_q}};

`ifdef INTC_NESTING_EN
    logic [NUM_SRC-1:0] isr_q;
    logic [NUM_SRC-1:0] isr_d;
    logic [NUM_SRC-1:0] isr_low;
    logic               wr_eoi;

    assign wr_eoi  = hit & memwt & (offset == 2'd3);
    assign isr_low = isr_q & (-isr_q);

    always_comb begin
        logic seen;
        seen = 1'b0;
        gate = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            seen    = seen | isr_q[i];
            gate[i] = ~seen;
        end
    end

    // EOI clear first, then the intack set, so both can land in one cycle
    always_comb begin
        isr_d = isr_q & ~(wr_eoi ? isr_low : '0);
        isr_d = isr_d | clr_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            isr_q <= '0;
        end else begin
            isr_q <= isr_d;
        end
    end
`else
    assign gate = '1;
`endif

    assign eligible = pend_q & mask_q & gate;
    assign win_oh   = eligible & (-eligible);
    assign any_elig = |eligible;
    assign int_req  = any_elig;

    always_comb begin
        win_idx = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = 4'(i);
            end
        end
        vec = any_elig ? (VEC_OFF4 + win_idx) : SPUR4;
    end

    // New edges are OR-ed in last so they win over both clear sources
    always_comb begin
        clr_ack = intack  ? win_oh : '0;
        clr_w1c = wr_pend ? wdata  : '0;
        pend_d  = (pend_q & ~(clr_ack | clr_w1c)) | set_edge;
    end

    always_comb begin
        reg_rd = 16'h0000;
        case (offset)
            2'd0:    reg_rd = 16'(mask_q);
            2'd1:    reg_rd = 16'(pend_q);
            2'd2:    reg_rd = {12'h000, vec};
`ifdef INTC_NESTING_EN
            default: reg_rd = 16'(isr_q);
`else
            default: reg_rd = 16'h0000;
`endif
        endcase
    end

    always_comb begin
        rd_sel  = intack | rd_hit;
        rd_data = 16'h0000;
        if (intack) begin
            rd_data = {12'h000, vec};
        end else if (rd_hit) begin
            rd_data = reg_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            pend_q  <= '0;
            req_d   <= '0;
            armed_q <= 1'b0;
        end else begin
            req_d   <= src_req;
            armed_q <= 1'b1;
            pend_q  <= pend_d;
            if (wr_mask) begin
                mask_q <= wdata;
            end
        end
    end

endmodule
